bsg_tb_host_ctrl: RTL and testbench

BSG_TB_HOST_CTRL -- requirements
Module: bsg_tb_host_ctrl

---
 rtl/bsg_tb_host_ctrl_pkg.sv | 18 +
 rtl/bsg_tb_host_ctrl_dff.sv | 21 ++
 rtl/bsg_tb_host_ctrl.sv | 74 +++++++
 tb/tb_bsg_tb_host_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/bsg_tb_host_ctrl_pkg.sv
`default_nettype none
// +---------------------------------------------------------------+
// | bsg_tb_host_ctrl_pkg: shared defaults and GPIO bit indices    |
// | Revision: 1.0                                                 |
// +---------------------------------------------------------------+
package bsg_tb_host_ctrl_pkg;

  localparam int default_ctr_width    = 64;
  localparam int default_gpio_width   = 2;
  localparam int default_chain_stages = 3;

  typedef enum int {
    gpio_trace_en = 0,
    gpio_log_en   = 1
  } gpio_bit_e;

endpackage
`default_nettype wire

// File: rtl/bsg_tb_host_ctrl_dff.sv
`default_nettype none
// +---------------------------------------------------------------+
// | bsg_tb_host_ctrl_dff: one async-reset register stage          |
// | Revision: 1.0                                                 |
// +---------------------------------------------------------------+
module bsg_tb_host_ctrl_dff #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) data_o <= '0;
    else         data_o <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/bsg_tb_host_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------+
// | bsg_tb_host_ctrl: delay chain, cycle counter and host GPIO    |
// | Revision: 1.0                                                 |
// +---------------------------------------------------------------+
module bsg_tb_host_ctrl
  import bsg_tb_host_ctrl_pkg::*;
#(
  parameter int                      chain_width_p     = 1,
  parameter int                      chain_stages_p    = default_chain_stages,
  parameter int                      ctr_width_p       = default_ctr_width,
  parameter int                      gpio_width_p      = default_gpio_width,
  parameter logic [gpio_width_p-1:0] gpio_init_p       = '0,
  parameter logic [gpio_width_p-1:0] gpio_use_output_p = {gpio_width_p{1'b1}}
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [chain_width_p-1:0] chain_data_i,
  output logic [chain_width_p-1:0] chain_data_o,
  output logic [ctr_width_p-1:0]   ctr_r_o,
  input  logic                     gpio_v_i,
  input  logic [gpio_width_p-1:0]  gpio_data_i,
  input  logic [gpio_width_p-1:0]  gpio_i,
  output logic [gpio_width_p-1:0]  gpio_o,
  output logic [gpio_width_p-1:0]  gpio_r_o
);

  logic [gpio_width_p-1:0] gpio_reg;

  generate
    if (chain_stages_p == 0) begin : g_chain_bypass
      assign chain_data_o = chain_data_i;
    end else begin : g_chain
      logic [chain_stages_p:0][chain_width_p-1:0] stage;
      assign stage[0] = chain_data_i;
      for (genvar i = 0; i < chain_stages_p; i++) begin : g_stage
        bsg_tb_host_ctrl_dff #(
          .width_p(chain_width_p)
        ) dff (
          .clk_i  (clk_i),
          .reset_i(reset_i),
          .data_i (stage[i]),
          .data_o (stage[i+1])
        );
      end
      assign chain_data_o = stage[chain_stages_p];
    end
  endgenerate

  // Free-running; wraps silently at all-ones.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) ctr_r_o <= '0;
    else         ctr_r_o <= ctr_r_o + ctr_width_p'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)       gpio_reg <= gpio_init_p;
    else if (gpio_v_i) gpio_reg <= gpio_data_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) gpio_r_o <= '0;
    else         gpio_r_o <= gpio_i;
  end

  // Input-mode bits bypass the register so the host sees live pins.
  generate
    for (genvar i = 0; i < gpio_width_p; i++) begin : g_gpio
      assign gpio_o[i] = gpio_use_output_p[i] ? gpio_reg[i] : gpio_i[i];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bsg_tb_host_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------+
// | tb_bsg_tb_host_ctrl: bench with default and alternate builds  |
// | Revision: 1.0                                                 |
// +---------------------------------------------------------------+
module tb_bsg_tb_host_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        chain_in;
  logic        gv;
  logic [1:0]  gd;
  logic [1:0]  gi;

  logic        chain_a, chain_b;
  logic [63:0] ctr_a;
  logic [3:0]  ctr_b;
  logic [1:0]  gpio_o_a, gpio_o_b, gpio_r_a, gpio_r_b;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  always #5 clk = ~clk;

  bsg_tb_host_ctrl dut_a (
    .clk_i       (clk),
    .reset_i     (rst),
    .chain_data_i(chain_in),
    .chain_data_o(chain_a),
    .ctr_r_o     (ctr_a),
    .gpio_v_i    (gv),
    .gpio_data_i (gd),
    .gpio_i      (gi),
    .gpio_o      (gpio_o_a),
    .gpio_r_o    (gpio_r_a)
  );

  bsg_tb_host_ctrl #(
    .chain_stages_p   (0),
    .ctr_width_p      (4),
    .gpio_use_output_p(2'b01)
  ) dut_b (
    .clk_i       (clk),
    .reset_i     (rst),
    .chain_data_i(chain_in),
    .chain_data_o(chain_b),
    .ctr_r_o     (ctr_b),
    .gpio_v_i    (gv),
    .gpio_data_i (gd),
    .gpio_i      (gi),
    .gpio_o      (gpio_o_b),
    .gpio_r_o    (gpio_r_b)
  );

  // Model: edges since reset, last three chain samples, host register, last pin sample.
  longint unsigned m_edges;
  bit              m_q[$];
  logic [1:0]      m_greg;
  logic [1:0]      m_gr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_edges = 0;
      m_q.delete();
      m_greg  = 2'b00;
      m_gr    = 2'b00;
    end else begin
      m_edges = m_edges + 1;
      m_q.push_back(chain_in);
      if (m_q.size() > 3) void'(m_q.pop_front());
      if (gv) m_greg = gd;
      m_gr = gi;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("m_chain_a", 64'(chain_a), (m_q.size() == 3) ? 64'(m_q[0]) : 64'd0);
      check("m_chain_b", 64'(chain_b), 64'(chain_in));
      check("m_ctr_a",   ctr_a,        m_edges);
      check("m_ctr_b",   64'(ctr_b),   m_edges % 16);
      check("m_gpio_a",  64'(gpio_o_a), 64'(m_greg));
      check("m_gpio_b",  64'(gpio_o_b), 64'({gi[1], m_greg[0]}));
      check("m_gpio_ra", 64'(gpio_r_a), 64'(m_gr));
      check("m_gpio_rb", 64'(gpio_r_b), 64'(m_gr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed vectors: {chain_in, gpio_v, gpio_data[1:0], gpio_i[1:0]}
  logic [5:0] vec [8] = '{6'b1_1_01_11, 6'b0_0_10_00, 6'b1_1_11_01, 6'b1_0_00_10,
                          6'b0_1_00_11, 6'b0_0_01_01, 6'b1_1_10_10, 6'b0_0_11_00};

  initial begin
    rst = 1'b1; chain_in = 1'b0; gv = 1'b0; gd = 2'b00; gi = 2'b00;
    repeat (4) tick();
    started = 1'b1;
    check("rst_ctr_a",  ctr_a, 64'd0);
    check("rst_ctr_b",  64'(ctr_b), 64'd0);
    check("rst_gpio_a", 64'(gpio_o_a), 64'd0);
    check("rst_gpio_r", 64'(gpio_r_a), 64'd0);
    check("rst_chain",  64'(chain_a), 64'd0);

    rst = 1'b0; chain_in = 1'b1;
    #1;
    check("byp_chain_hi", 64'(chain_b), 64'd1);
    tick();
    check("ctr_first", ctr_a, 64'd1);
    check("chain_e1", 64'(chain_a), 64'd0);
    gv = 1'b1; gd = 2'b10; gi = 2'b10;
    #1;
    check("gpio_nobypass", 64'(gpio_o_a), 64'd0);
    check("gpio_in_live",  64'(gpio_o_b), 64'b10);
    check("gpio_r_late",   64'(gpio_r_b), 64'd0);
    tick();
    check("gpio_write",  64'(gpio_o_a), 64'b10);
    check("gpio_r_b",    64'(gpio_r_b), 64'b10);
    check("chain_e2",    64'(chain_a), 64'd0);
    gv = 1'b0; gd = 2'b01;
    tick();
    check("chain_e3",  64'(chain_a), 64'd1);
    check("gpio_hold", 64'(gpio_o_a), 64'b10);
    chain_in = 1'b0;
    #1;
    check("byp_chain_lo", 64'(chain_b), 64'd0);
    repeat (7) tick();
    check("ctr_ten",   ctr_a, 64'd10);
    repeat (5) tick();
    check("ctr_b_15",  64'(ctr_b), 64'd15);
    tick();
    check("ctr_b_wrap", 64'(ctr_b), 64'd0);
    check("ctr_a_16",   ctr_a, 64'd16);

    chain_in = 1'b1; gi = 2'b01;
    repeat (3) tick();
    check("chain_pre_rst", 64'(chain_a), 64'd1);
    check("gpio_r_pre",    64'(gpio_r_a), 64'b01);
    #2 rst = 1'b1;
    #1;
    check("async_ctr",    ctr_a, 64'd0);
    check("async_chain",  64'(chain_a), 64'd0);
    check("async_gpio",   64'(gpio_o_a), 64'd0);
    check("async_gpio_r", 64'(gpio_r_a), 64'd0);
    gv = 1'b1; gd = 2'b11;
    repeat (2) tick();
    gv = 1'b0; rst = 1'b0;
    repeat (2) tick();
    check("flush_chain",  64'(chain_a), 64'd0);
    check("rst_wr_ign",   64'(gpio_o_a), 64'd0);
    check("ctr_restart",  ctr_a, 64'd2);
    tick();
    check("refill_chain", 64'(chain_a), 64'd1);

    for (int i = 0; i < 8; i++) begin
      {chain_in, gv, gd, gi} = vec[i];
      tick();
    end
    gv = 1'b0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
